fifo_controller: RTL and testbench
==================================

Name: fifo_controller

Overview:
Control FSM for the 15-entry register-file FIFO in the midterm datapath.
- Accepts write and read requests and sequences the register file.
- Owns the write and read address pointers, the occupancy count, full/empty flags, and ack/error handshakes.
- The register file and its data path sit outside; this block only generates write/read strobes and addresses.

Parameters:
DEPTH, 15, number of register-file entries; pointers wrap from DEPTH-1 to 0
AW, 4, address/pointer width; must satisfy 2**AW >= DEPTH
CW, 4, occupancy count width; must satisfy 2**CW > DEPTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request, sampled every rising edge
rd_en  input  1  read request, sampled every rising edge
rf_we  output  1  register-file write strobe; combinational
rf_re  output  1  register-file read strobe; combinational
wr_addr  output  AW  register-file write address (tail pointer)
rd_addr  output  AW  register-file read address (head pointer)
state  output  3  current FSM state
data_count  output  CW  number of valid entries, 0..DEPTH
full  output  1  data_count == DEPTH
empty  output  1  data_count == 0
wr_ack  output  1  previous cycle's write accepted
wr_err  output  1  previous cycle's write rejected (full)
rd_ack  output  1  previous cycle's read accepted
rd_err  output  1  previous cycle's read rejected (empty)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = INIT
  - wr_addr = rd_addr = 0, data_count = 0
  - empty = 1, full = 0
  - all acks and errors = 0
- State encoding: INIT=0, NO_OP=1, WRITE=2, WR_ERROR=3, READ=4, RD_ERROR=5; values 6-7 are unused and recover to NO_OP.
- Next-state decision uses the sampled inputs and current flags; it is independent of the current state.
  - wr_en=0, rd_en=0 -> NO_OP
  - wr_en=1, rd_en=1 -> NO_OP; no pointer or count change (baseline)
  - wr_en=1, rd_en=0: if full -> WR_ERROR, else WRITE
  - rd_en=1, wr_en=0: if empty -> RD_ERROR, else READ
- Strobes (combinational, same cycle as the request):
  - rf_we = wr_en & ~rd_en & ~full
  - rf_re = rd_en & ~wr_en & ~empty
- Register file timing:
  - The register file writes at wr_addr on the edge ending an rf_we cycle.
  - Read data at rd_addr is valid combinationally during the rf_re cycle and is captured by the datapath at that edge.
- Pointer and count updates on that same edge:
  - rf_we: wr_addr advances by 1, wrapping DEPTH-1 -> 0; data_count increments.
  - rf_re: rd_addr advances by 1 with the same wrap; data_count decrements.
- full and empty are combinational decodes of the registered data_count.
- Handshakes are a Moore decode of state, so they have 1-cycle latency:
  - wr_ack = (state==WRITE), wr_err = (state==WR_ERROR)
  - rd_ack = (state==READ), rd_err = (state==RD_ERROR)
  - Each flag holds for exactly one cycle per request cycle; back-to-back requests give continuous assertion.
- Error cycles leave pointers, count and register-file contents unchanged.
- data_count never exceeds DEPTH and never underflows below 0.
- Reset asserted mid-operation immediately returns all outputs to reset values. Register-file contents are not cleared but are unreachable (empty=1).

Optional Feature:
FIFO_SIMUL_RW_EN:
- Defined:
  - wr_en & rd_en with data_count > 0 enters new state WRRD=6.
  - Both strobes assert and both pointers advance; data_count is unchanged.
  - wr_ack and rd_ack both assert next cycle.
  - With wr_en & rd_en while empty: a write-only cycle (WRITE) plus RD_ERROR is not possible in one state, so this case goes to RD_ERROR and nothing is written.
  - Simultaneous requests while full are legal; the read frees a slot in the same cycle.
- Undefined: baseline NO_OP rule applies, and encoding 6 is unused.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - the state enum (INIT..WRRD) and its 3-bit width
  - DEPTH_DEFAULT=15, AW_DEFAULT=4, CW_DEFAULT=4
- Sub-module fifo_ptr: AW-bit wrap counter with en and asynchronous active-low reset. It wraps at DEPTH-1 and is instantiated twice, once for wr_addr and once for rd_addr.

Test Plan:
- Reset then idle 3 cycles -> state=1 (NO_OP), empty=1, full=0, data_count=0, wr_addr=rd_addr=0, no ack/err.
- 15 consecutive writes -> rf_we high for 15 cycles, wr_addr sequence 0..14 then 0, data_count=15, full=1.
  - A 16th write -> rf_we=0, state=3, wr_err=1 one cycle later, count stays 15.
- Read from empty after reset -> rf_re=0, state=5, rd_err=1 next cycle, rd_addr stays 0.
- Wrap: write 15, read 15, write 3 -> wr_addr ends at 3 and rd_addr at 0, data_count=3; reads 0,1,2 return the last 3 written values.
- wr_en=rd_en=1 with count=5 -> baseline: state=1, count 5, no strobes; with FIFO_SIMUL_RW_EN: state=6, both pointers +1, count 5, wr_ack=rd_ack=1.
- Write 7 entries, assert rst_n=0 mid-write asynchronously -> outputs reset with no clock edge needed; the next read gives rd_err.

Source files
------------

// File: rtl/fifo_controller_pkg.sv
// Shared types and defaults for the 15-entry register-file FIFO controller.
package fifo_ctrl_pkg;

  localparam int STATE_W       = 3;
  localparam int DEPTH_DEFAULT = 15;
  localparam int AW_DEFAULT    = 4;
  localparam int CW_DEFAULT    = 4;

  typedef enum logic [STATE_W-1:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5,
    WRRD     = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_ptr.sv
// Register-file address pointer: advances on en_i and wraps from DEPTH-1 back to 0.
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [AW-1:0] ptr_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_controller.sv
// Control FSM for the register-file FIFO: strobes, pointers, occupancy and handshakes.
// Define FIFO_SIMUL_RW_EN to allow a combined read+write cycle (state WRRD).
module fifo_controller
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int CW    = CW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic               rf_we,
  output logic               rf_re,
  output logic [AW-1:0]      wr_addr,
  output logic [AW-1:0]      rd_addr,
  output logic [STATE_W-1:0] state,
  output logic [CW-1:0]      data_count,
  output logic               full,
  output logic               empty,
  output logic               wr_ack,
  output logic               wr_err,
  output logic               rd_ack,
  output logic               rd_err
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

`ifdef FIFO_SIMUL_RW_EN
  logic both_ok;
  // A combined cycle needs something to read; the read frees a slot even when full.
  assign both_ok = wr_en & rd_en & ~empty;
  assign rf_we   = (wr_en & ~rd_en & ~full) | both_ok;
  assign rf_re   = (rd_en & ~wr_en & ~empty) | both_ok;
`else
  assign rf_we = wr_en & ~rd_en & ~full;
  assign rf_re = rd_en & ~wr_en & ~empty;
`endif

  // Next state depends only on requests and flags, so encodings 6/7 fall back to NO_OP.
  always_comb begin
    state_d = NO_OP;
    case ({wr_en, rd_en})
      2'b10:   state_d = full  ? WR_ERROR : WRITE;
      2'b01:   state_d = empty ? RD_ERROR : READ;
`ifdef FIFO_SIMUL_RW_EN
      2'b11:   state_d = empty ? RD_ERROR : WRRD;
`endif
      default: state_d = NO_OP;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (rf_we && !rf_re)      count_d = count_q + CW'(1);
    else if (rf_re && !rf_we) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (rf_we),
    .ptr_o (wr_addr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (rf_re),
    .ptr_o (rd_addr)
  );

  assign state      = state_q;
  assign data_count = count_q;
  assign wr_ack     = (state_q == WRITE)    || (state_q == WRRD);
  assign wr_err     = (state_q == WR_ERROR);
  assign rd_ack     = (state_q == READ)     || (state_q == WRRD);
  assign rd_err     = (state_q == RD_ERROR);

endmodule

// File: tb/tb_fifo_controller.sv
// Scoreboard bench for fifo_controller: driver queues expected outputs, negedge monitor checks them.
module tb_fifo_controller;
  import fifo_ctrl_pkg::*;

  localparam int DEPTH = 15;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en;
  logic       rf_we, rf_re, full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0] wr_addr, rd_addr, data_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  fifo_controller #(.DEPTH(15), .AW(4), .CW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rf_we      (rf_we),
    .rf_re      (rf_re),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .state      (state),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  typedef struct {
    string      tag;
    logic [22:0] v;
    logic       chk_rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mem [0:15];
  logic [7:0] wdata;
  int         n_vec = 0;
  int         n_miss = 0;

  // Reference model state (registered values after the most recent edge)
  int         m_st, m_cnt, m_wp, m_rp;
  logic       p_wr, p_rd;
  logic [7:0] p_wdata;
  logic [7:0] dq[$];

  // Bench-side register file driven by the controller's strobes
  always @(posedge clk) if (rf_we) mem[wr_addr] <= wdata;

  function automatic void ref_strobes(input int cnt, input logic w, input logic r,
                                      output logic we, output logic re);
    we = w && !r && (cnt < DEPTH);
    re = r && !w && (cnt > 0);
`ifdef FIFO_SIMUL_RW_EN
    if (w && r && cnt > 0) begin
      we = 1'b1;
      re = 1'b1;
    end
`endif
  endfunction

  function automatic int ref_next(input int cnt, input logic w, input logic r);
    if (w && !r) return (cnt == DEPTH) ? 3 : 2;
    if (r && !w) return (cnt == 0) ? 5 : 4;
`ifdef FIFO_SIMUL_RW_EN
    if (w && r) return (cnt == 0) ? 5 : 6;
`endif
    return 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_wp = 0; m_rp = 0;
    dq.delete();
  endtask

  task automatic model_step();
    logic we, re;
    ref_strobes(m_cnt, p_wr, p_rd, we, re);
    m_st = ref_next(m_cnt, p_wr, p_rd);
    if (re) begin
      void'(dq.pop_front());
      m_rp = (m_rp + 1) % DEPTH;
      m_cnt = m_cnt - 1;
    end
    if (we) begin
      dq.push_back(p_wdata);
      m_wp = (m_wp + 1) % DEPTH;
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    logic we, re;
    logic wack, werr, rack, rerr;
    ref_strobes(m_cnt, wr_en, rd_en, we, re);
    wack = (m_st == 2) || (m_st == 6);
    werr = (m_st == 3);
    rack = (m_st == 4) || (m_st == 6);
    rerr = (m_st == 5);
    e.tag    = tag;
    e.v      = {we, re, 4'(m_wp), 4'(m_rp), 3'(m_st), 4'(m_cnt),
                (m_cnt == DEPTH), (m_cnt == 0), wack, werr, rack, rerr};
    e.chk_rd = re;
    e.rdata  = (re && dq.size() > 0) ? dq[0] : 8'h00;
    sbq.push_back(e);
  endtask

  task automatic cycle(input logic w, input logic r, input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    wr_en   = w;
    rd_en   = r;
    wdata   = wdata + 8'd7;
    p_wr    = w;
    p_rd    = r;
    p_wdata = wdata;
    push_exp(tag);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    wr_en = 1'b1;
    rd_en = 1'b0;
    wdata = wdata + 8'd7;
    #1;
    rst_n = 1'b0;
    model_reset();
    push_exp("async_rst");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    p_wr  = 1'b0;
    p_rd  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t        e;
      logic [22:0] act;
      e   = sbq.pop_front();
      act = {rf_we, rf_re, wr_addr, rd_addr, state, data_count,
             full, empty, wr_ack, wr_err, rd_ack, rd_err};
      n_vec++;
      if (act !== e.v || (e.chk_rd && mem[rd_addr] !== e.rdata)) begin
        n_miss++;
        $display("FAIL %s @%0t: got we/re=%b%b wa=%0d ra=%0d st=%0d cnt=%0d f/e=%b%b ack/err=%b%b%b%b rdata=%h, expected we/re=%b%b wa=%0d ra=%0d st=%0d cnt=%0d f/e=%b%b ack/err=%b%b%b%b rdata=%h",
                 e.tag, $time, act[22], act[21], act[20:17], act[16:13], act[12:10], act[9:6],
                 act[5], act[4], act[3], act[2], act[1], act[0], mem[rd_addr],
                 e.v[22], e.v[21], e.v[20:17], e.v[16:13], e.v[12:10], e.v[9:6],
                 e.v[5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0], e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wdata = 8'h00; p_wr = 1'b0; p_rd = 1'b0; p_wdata = 8'h00;
    model_reset();
    #1 push_exp("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    repeat (3)  cycle(1'b0, 1'b0, "idle");
    cycle(1'b0, 1'b1, "rd_empty");
    cycle(1'b0, 1'b0, "rd_err");
    repeat (15) cycle(1'b1, 1'b0, "fill");
    cycle(1'b1, 1'b0, "wr_full");
    cycle(1'b0, 1'b0, "wr_err");
    repeat (15) cycle(1'b0, 1'b1, "drain");
    cycle(1'b0, 1'b1, "rd_empty2");
    repeat (3)  cycle(1'b1, 1'b0, "wrap_wr");
    repeat (3)  cycle(1'b0, 1'b1, "wrap_rd");
    cycle(1'b1, 1'b1, "rw_empty");
    repeat (5)  cycle(1'b1, 1'b0, "w5");
    cycle(1'b1, 1'b1, "rw_cnt5");
    cycle(1'b0, 1'b0, "rw_ack");
    repeat (10) cycle(1'b1, 1'b0, "fill2");
    cycle(1'b1, 1'b1, "rw_full");
    cycle(1'b0, 1'b0, "rw_full_ack");
    repeat (15) cycle(1'b0, 1'b1, "drain2");
    cycle(1'b0, 1'b0, "idle2");
    repeat (7)  cycle(1'b1, 1'b0, "w7");
    reset_mid();
    cycle(1'b0, 1'b1, "rd_after_rst");
    cycle(1'b0, 1'b0, "rd_err_after_rst");

    repeat (3) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
